// File: rtl/main.sv
// -----------------------------------------------------------------------------
// main -- 8-bit operand-register ALU with a 2-bit control FSM.
//
// Two operand registers (A, B) are cleared, loaded from num1/num2, or held
// according to in_sel. A one-hot out_sel picks one of seven operations. The
// result is registered on out while the FSM is in EXEC. The FSM state and its
// combinational next state are exported for monitoring.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous, active-high reset
//   on         in   1  enable; 0 forces OFF and holds all data registers
//   in_sel     in   3  operand mux control {persist, load, clear}
//   num1       in   8  operand source for A
//   num2       in   8  operand source for B
//   out_sel    in   7  one-hot operation select
//   out        out  8  registered ALU result
//   currState  out  2  current FSM state
//   nextState  out  2  combinational next FSM state
//
// Handshake: none. Inputs are sampled on every rising edge while on=1; there
// is no valid/ready flow control and no back-pressure.
// -----------------------------------------------------------------------------
module main (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic [2:0] in_sel,
  input  logic [7:0] num1,
  input  logic [7:0] num2,
  input  logic [6:0] out_sel,
  output logic [7:0] out,
  output logic [1:0] currState,
  output logic [1:0] nextState
);

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    IDLE = 2'b01,
    LOAD = 2'b10,
    EXEC = 2'b11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_out;
  logic [7:0] w_alu;

  assign currState = r_state;
  assign nextState = w_next;
  assign out       = r_out;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OFF;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; on=0 overrides every transition.
  always_comb begin
    w_next = r_state;
    if (!on) begin
      w_next = OFF;
    end else begin
      case (r_state)
        OFF:  w_next = IDLE;
        IDLE: w_next = in_sel[1] ? LOAD : IDLE;
        LOAD: w_next = EXEC;
        EXEC: begin
          if (in_sel[0])      w_next = IDLE;
          else if (in_sel[1]) w_next = LOAD;
          else                w_next = EXEC;
        end
        default: w_next = OFF;
      endcase
    end
  end

  // Operand registers. Updates do not depend on the FSM state, so a load on
  // the OFF->IDLE edge still captures. The persist bit is a don't-care: any
  // code without clear or load holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= 8'h00;
      r_b <= 8'h00;
    end else if (on) begin
      casez (in_sel)
        3'b??1: begin
          r_a <= 8'h00;
          r_b <= 8'h00;
        end
        3'b?10: begin
          r_a <= num1;
          r_b <= num2;
        end
        default: begin
          r_a <= r_a;
          r_b <= r_b;
        end
      endcase
    end
  end

  // ALU; anything other than exactly one select bit yields zero.
  always_comb begin
    w_alu = 8'h00;
    case (out_sel)
      7'b000_0001: w_alu = r_a + r_b;
      7'b000_0010: w_alu = r_a - r_b;
      7'b000_0100: w_alu = r_a & r_b;
      7'b000_1000: w_alu = r_a | r_b;
      7'b001_0000: w_alu = r_a ^ r_b;
      7'b010_0000: w_alu = ~r_a;
      7'b100_0000: w_alu = {r_a[6:0], 1'b0};
      default:     w_alu = 8'h00;
    endcase
  end

  // Output register: clear wins over EXEC; other states hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= 8'h00;
    end else if (on) begin
      if (in_sel[0]) begin
        r_out <= 8'h00;
      end else if (r_state == EXEC) begin
        r_out <= w_alu;
      end
    end
  end

endmodule

// File: tb/tb_main.sv
// -----------------------------------------------------------------------------
// tb_main -- directed testbench for main (operand-register ALU + FSM).
// -----------------------------------------------------------------------------
module tb_main;

  logic       clk;
  logic       rst;
  logic       on;
  logic [2:0] in_sel;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [6:0] out_sel;
  logic [7:0] out;
  logic [1:0] currState;
  logic [1:0] nextState;

  int n_tests;
  int n_fail;

  localparam logic [1:0] S_OFF  = 2'b00;
  localparam logic [1:0] S_IDLE = 2'b01;
  localparam logic [1:0] S_LOAD = 2'b10;
  localparam logic [1:0] S_EXEC = 2'b11;

  localparam logic [6:0] OP_ADD = 7'b000_0001;
  localparam logic [6:0] OP_SUB = 7'b000_0010;
  localparam logic [6:0] OP_AND = 7'b000_0100;
  localparam logic [6:0] OP_OR  = 7'b000_1000;
  localparam logic [6:0] OP_XOR = 7'b001_0000;
  localparam logic [6:0] OP_NOT = 7'b010_0000;
  localparam logic [6:0] OP_SHL = 7'b100_0000;

  main dut (
    .clk       (clk),
    .rst       (rst),
    .on        (on),
    .in_sel    (in_sel),
    .num1      (num1),
    .num2      (num2),
    .out_sel   (out_sel),
    .out       (out),
    .currState (currState),
    .nextState (nextState)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; returns 1 time unit after it so outputs are
  // settled and new inputs land well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: from EXEC (or IDLE) load a/b and return in EXEC.
  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    in_sel = 3'b010;
    num1   = a;
    num2   = b;
    tick();
    in_sel = 3'b000;
    tick();
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    on      = 1'b0;
    in_sel  = 3'b000;
    num1    = 8'h00;
    num2    = 8'h00;
    out_sel = 7'b0;
    tick();
    tick();
    n_tests++;
    if (out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out: got %h expected %h", out, 8'h00);
    end
    n_tests++;
    if (currState !== S_OFF) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", currState, S_OFF);
    end
    rst = 1'b0;
    on  = 1'b1;
    #1;
    n_tests++;
    if (nextState !== S_IDLE) begin
      n_fail++;
      $display("FAIL off_next: got %b expected %b", nextState, S_IDLE);
    end
    tick();
    n_tests++;
    if (currState !== S_IDLE) begin
      n_fail++;
      $display("FAIL off_to_idle: got %b expected %b", currState, S_IDLE);
    end
  endtask

  task automatic test_load_or();
    in_sel  = 3'b010;
    num1    = 8'h57;
    num2    = 8'h1A;
    out_sel = OP_OR;
    #1;
    n_tests++;
    if (nextState !== S_LOAD) begin
      n_fail++;
      $display("FAIL idle_next_load: got %b expected %b", nextState, S_LOAD);
    end
    tick();
    n_tests++;
    if (currState !== S_LOAD || out !== 8'h00) begin
      n_fail++;
      $display("FAIL load_state: got state %b out %h expected %b %h",
               currState, out, S_LOAD, 8'h00);
    end
    in_sel = 3'b000;
    tick();
    n_tests++;
    if (currState !== S_EXEC || out !== 8'h00) begin
      n_fail++;
      $display("FAIL exec_entry: got state %b out %h expected %b %h",
               currState, out, S_EXEC, 8'h00);
    end
    tick();
    n_tests++;
    if (out !== 8'h5F) begin
      n_fail++;
      $display("FAIL or_result: got %h expected %h", out, 8'h5F);
    end
  endtask

  task automatic test_persist_sub();
    in_sel  = 3'b000;
    num1    = 8'h00;
    num2    = 8'h01;
    out_sel = OP_SUB;
    tick();
    n_tests++;
    if (out !== 8'h3D || currState !== S_EXEC) begin
      n_fail++;
      $display("FAIL persist_sub: got out %h state %b expected %h %b",
               out, currState, 8'h3D, S_EXEC);
    end
    // persist bit alone must also hold operands
    in_sel  = 3'b100;
    out_sel = OP_AND;
    tick();
    n_tests++;
    if (out !== 8'h12 || currState !== S_EXEC) begin
      n_fail++;
      $display("FAIL persist_and: got out %h state %b expected %h %b",
               out, currState, 8'h12, S_EXEC);
    end
    in_sel = 3'b000;
  endtask

  task automatic test_ops();
    out_sel = OP_SUB;
    load_ops(8'hFF, 8'h01);
    n_tests++;
    if (out !== 8'h3D) begin
      n_fail++;
      $display("FAIL load_hold: got %h expected %h", out, 8'h3D);
    end
    out_sel = OP_ADD;
    tick();
    n_tests++;
    if (out !== 8'h00) begin
      n_fail++;
      $display("FAIL add_wrap: got %h expected %h", out, 8'h00);
    end
    load_ops(8'h00, 8'h01);
    out_sel = OP_SUB;
    tick();
    n_tests++;
    if (out !== 8'hFF) begin
      n_fail++;
      $display("FAIL sub_wrap: got %h expected %h", out, 8'hFF);
    end
    load_ops(8'h57, 8'h1A);
    out_sel = OP_NOT;
    tick();
    n_tests++;
    if (out !== 8'hA8) begin
      n_fail++;
      $display("FAIL not_a: got %h expected %h", out, 8'hA8);
    end
    out_sel = OP_SHL;
    tick();
    n_tests++;
    if (out !== 8'hAE) begin
      n_fail++;
      $display("FAIL shl_a: got %h expected %h", out, 8'hAE);
    end
    out_sel = OP_XOR;
    tick();
    n_tests++;
    if (out !== 8'h4D) begin
      n_fail++;
      $display("FAIL xor_ab: got %h expected %h", out, 8'h4D);
    end
  endtask

  task automatic test_invalid_sel();
    out_sel = OP_ADD;
    tick();
    n_tests++;
    if (out !== 8'h71) begin
      n_fail++;
      $display("FAIL add_ab: got %h expected %h", out, 8'h71);
    end
    out_sel = 7'b000_0000;
    tick();
    n_tests++;
    if (out !== 8'h00) begin
      n_fail++;
      $display("FAIL sel_zero: got %h expected %h", out, 8'h00);
    end
    out_sel = OP_XOR;
    tick();
    out_sel = 7'b000_0011;
    tick();
    n_tests++;
    if (out !== 8'h00) begin
      n_fail++;
      $display("FAIL sel_multi: got %h expected %h", out, 8'h00);
    end
  endtask

  task automatic test_clear();
    out_sel = OP_ADD;
    tick();
    in_sel = 3'b001;
    #1;
    n_tests++;
    if (nextState !== S_IDLE) begin
      n_fail++;
      $display("FAIL clear_next: got %b expected %b", nextState, S_IDLE);
    end
    tick();
    n_tests++;
    if (out !== 8'h00 || currState !== S_IDLE) begin
      n_fail++;
      $display("FAIL clear_exec: got out %h state %b expected %h %b",
               out, currState, 8'h00, S_IDLE);
    end
    in_sel = 3'b000;
    tick();
    n_tests++;
    if (currState !== S_IDLE) begin
      n_fail++;
      $display("FAIL idle_hold: got %b expected %b", currState, S_IDLE);
    end
  endtask

  task automatic test_off_hold();
    load_ops(8'h57, 8'h1A);
    out_sel = OP_ADD;
    tick();
    on     = 1'b0;
    in_sel = 3'b001;
    #1;
    n_tests++;
    if (nextState !== S_OFF) begin
      n_fail++;
      $display("FAIL off_next: got %b expected %b", nextState, S_OFF);
    end
    tick();
    n_tests++;
    if (out !== 8'h71 || currState !== S_OFF) begin
      n_fail++;
      $display("FAIL off_hold: got out %h state %b expected %h %b",
               out, currState, 8'h71, S_OFF);
    end
    tick();
    n_tests++;
    if (out !== 8'h71 || currState !== S_OFF) begin
      n_fail++;
      $display("FAIL off_hold2: got out %h state %b expected %h %b",
               out, currState, 8'h71, S_OFF);
    end
    // Back on with persist: operands were held through OFF.
    on     = 1'b1;
    in_sel = 3'b000;
    tick();
    in_sel = 3'b010;
    num1   = 8'h57;
    num2   = 8'h1A;
    tick();
    in_sel  = 3'b000;
    out_sel = OP_SUB;
    tick();
    tick();
    n_tests++;
    if (out !== 8'h3D || currState !== S_EXEC) begin
      n_fail++;
      $display("FAIL resume_exec: got out %h state %b expected %h %b",
               out, currState, 8'h3D, S_EXEC);
    end
  endtask

  task automatic test_async_rst();
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out !== 8'h00 || currState !== S_OFF) begin
      n_fail++;
      $display("FAIL async_rst: got out %h state %b expected %h %b",
               out, currState, 8'h00, S_OFF);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_load_or();
    test_persist_sub();
    test_ops();
    test_invalid_sel();
    test_clear();
    test_off_hold();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
